// File: rtl/cam_stim_pkg.sv
// Shared definitions for the camera stimulus generator.
// Holds the pattern mode encodings, the FSM state type, the LFSR seed/tap constants,
// the default timing constants and the LFSR step function.
// Optional feature macro: CAM_STIM_LFSR_EN (enables the LFSR pattern for mode 3).
package cam_stim_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_HRAMP = 2'd1,
        MODE_XY    = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,15,13,4 expressed as bit positions 15,14,12,3 of a left-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    localparam int unsigned DEF_H_ACTIVE     = 160;
    localparam int unsigned DEF_V_ACTIVE     = 120;
    localparam int unsigned DEF_BYTES_PER_PX = 2;
    localparam int unsigned DEF_H_BLANK      = 4;
    localparam int unsigned DEF_V_BLANK      = 4;
    localparam int unsigned DEF_VSYNC_LINES  = 2;
    localparam int unsigned DEF_PCLK_DIV     = 2;

    // Fibonacci step: feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cam_stim_gen_if.sv
// Camera-side bus of the stimulus generator.
// Signals: CAM_pclk (pixel clock), CAM_vsync (frame sync), CAM_href (line valid),
// CAM_px_data (pixel byte). master = generator side, slave = consumer side.
// Optional feature macro: CAM_STIM_LFSR_EN (no effect on this file).
interface cam_stim_gen_if;
    logic       CAM_pclk;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_px_data;

    modport master (output CAM_pclk, output CAM_vsync, output CAM_href, output CAM_px_data);
    modport slave  (input CAM_pclk, input CAM_vsync, input CAM_href, input CAM_px_data);
endinterface

// File: rtl/cam_stim_pattern.sv
// Pixel value generator for the camera stimulus generator.
// Ports: clk/rst (sync active-high), seed_i (frame start, reload LFSR), adv_i (pixel done,
// step LFSR), x_i/y_i (pixel column/row), mode_i/solid_i (values latched at frame start),
// px_o (16-bit pixel value).
// Optional feature macro: CAM_STIM_LFSR_EN. When undefined, mode 3 falls back to the solid
// value and no LFSR register exists.
module cam_stim_pattern
    import cam_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_i,
    input  logic        adv_i,
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  mode_e       mode_i,
    input  logic [15:0] solid_i,
    output logic [15:0] px_o
);

`ifdef CAM_STIM_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Seed wins over advance so each frame starts from the seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_i) begin
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_lfsr_ports;
    assign unused_lfsr_ports = ^{clk, rst, seed_i, adv_i};
`endif

    logic unused_y_hi;
    assign unused_y_hi = ^y_i[15:8];

    always_comb begin
        px_o = solid_i;
        case (mode_i)
            MODE_SOLID: px_o = solid_i;
            MODE_HRAMP: px_o = x_i;
            MODE_XY:    px_o = {y_i[7:0], x_i[7:0]};
`ifdef CAM_STIM_LFSR_EN
            MODE_LFSR:  px_o = lfsr_q;
`else
            MODE_LFSR:  px_o = solid_i;
`endif
            default:    px_o = solid_i;
        endcase
    end

endmodule

// File: rtl/cam_stim_gen.sv
// Camera (DVP-style) stimulus generator: produces pclk, vsync, href and pixel bytes for
// synthetic frames (solid, horizontal ramp, x/y, optional LFSR).
// Ports: clk, rst (sync active-high), en (frame enable), mode/solid_px (sampled at frame
// start), cam (master side of cam_stim_gen_if), frame_done (1-clk pulse per frame),
// frame_cnt (completed frames, wraps).
// Optional feature macro: CAM_STIM_LFSR_EN (compiles the LFSR pattern for mode 3).
module cam_stim_gen
    import cam_stim_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned BYTES_PER_PX = DEF_BYTES_PER_PX,
    parameter int unsigned H_BLANK      = DEF_H_BLANK,
    parameter int unsigned V_BLANK      = DEF_V_BLANK,
    parameter int unsigned VSYNC_LINES  = DEF_VSYNC_LINES,
    parameter int unsigned PCLK_DIV     = DEF_PCLK_DIV
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [15:0]    solid_px,
    cam_stim_gen_if.master cam,
    output logic           frame_done,
    output logic [15:0]    frame_cnt
);

    localparam int unsigned ActBytes   = H_ACTIVE * BYTES_PER_PX;
    localparam int unsigned LineLen    = ActBytes + H_BLANK;
    localparam int unsigned FrameLines = V_BLANK + V_ACTIVE;
    localparam int unsigned BW         = $clog2(LineLen + 1);
    localparam int unsigned LW         = $clog2(FrameLines + 1);
    localparam int unsigned DW         = $clog2(PCLK_DIV + 1);

    localparam logic [BW-1:0] ByteLast = BW'(LineLen - 1);
    localparam logic [BW-1:0] ActEnd   = BW'(ActBytes);
    localparam logic [LW-1:0] LineLast = LW'(FrameLines - 1);
    localparam logic [LW-1:0] VBlankL  = LW'(V_BLANK);
    localparam logic [LW-1:0] VsyncEnd = LW'(VSYNC_LINES);
    localparam logic [DW-1:0] DivLast  = DW'(PCLK_DIV - 1);

    localparam bit ParamsOk = ((BYTES_PER_PX == 1) || (BYTES_PER_PX == 2)) &&
                              (VSYNC_LINES >= 1) && (VSYNC_LINES < V_BLANK) &&
                              (PCLK_DIV >= 1) && (H_ACTIVE >= 1) && (V_ACTIVE >= 1);
    if (!ParamsOk) begin : g_bad_params
        $fatal(1, "cam_stim_gen: illegal parameter set");
    end

    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    state_e        state_q, state_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [LW-1:0] line_q, line_d;
    mode_e         mode_q, mode_d;
    logic [15:0]   solid_q, solid_d;
    logic          done_q, done_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic        tick, fall, start, href, adv;
    logic [15:0] x_px, y_px, px;

    always_comb begin
        tick   = (div_q == DivLast);
        fall   = tick && pclk_q;
        div_d  = tick ? '0 : div_q + DW'(1);
        pclk_d = tick ? ~pclk_q : pclk_q;

        state_d = state_q;
        byte_d  = byte_q;
        line_d  = line_q;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;
        start   = 1'b0;

        if (fall) begin
            case (state_q)
                StIdle: begin
                    if (en) begin
                        state_d = StRun;
                        start   = 1'b1;
                    end
                end
                StRun: begin
                    if (byte_q == ByteLast) begin
                        byte_d = '0;
                        if (line_q == LineLast) begin
                            // Frame end: en only decides whether another frame follows.
                            line_d  = '0;
                            done_d  = 1'b1;
                            fcnt_d  = fcnt_q + 16'd1;
                            state_d = en ? StRun : StIdle;
                            start   = en;
                        end else begin
                            line_d = line_q + LW'(1);
                        end
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        mode_d  = start ? mode_e'(mode) : mode_q;
        solid_d = start ? solid_px : solid_q;

        href = (state_q == StRun) && (line_q >= VBlankL) && (byte_q < ActEnd);
        // Step the LFSR as the last byte of a pixel leaves the bus.
        adv  = fall && href && ((BYTES_PER_PX == 1) || byte_q[0]);
        x_px = 16'(byte_q >> (BYTES_PER_PX - 1));
        y_px = 16'(line_q) - 16'(V_BLANK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            pclk_q  <= 1'b0;
            state_q <= StIdle;
            byte_q  <= '0;
            line_q  <= '0;
            mode_q  <= MODE_SOLID;
            solid_q <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    cam_stim_pattern u_pattern (
        .clk     (clk),
        .rst     (rst),
        .seed_i  (start),
        .adv_i   (adv),
        .x_i     (x_px),
        .y_i     (y_px),
        .mode_i  (mode_q),
        .solid_i (solid_q),
        .px_o    (px)
    );

    // Outputs decode registered state only, so they move solely on the fall strobe.
    assign cam.CAM_pclk    = pclk_q;
    assign cam.CAM_vsync   = (state_q == StRun) && (line_q < VsyncEnd);
    assign cam.CAM_href    = href;
    assign cam.CAM_px_data = href ? (((BYTES_PER_PX == 2) && !byte_q[0]) ? px[15:8] : px[7:0])
                                  : 8'h00;
    assign frame_done      = done_q;
    assign frame_cnt       = fcnt_q;

endmodule

// File: tb/tb_cam_stim_gen.sv
// Self-checking bench for cam_stim_gen: table-driven line checks, a frame-level reference
// model, randomized back-to-back frames and hand-written reset / enable sequences.
// Optional feature macro: CAM_STIM_LFSR_EN (selects the expected mode-3 behaviour).
module tb_cam_stim_gen;

    localparam int H_ACT = 4;
    localparam int V_ACT = 3;
    localparam int BPP = 2;
    localparam int H_BLK = 4;
    localparam int V_BLK = 4;
    localparam int VS_LINES = 2;
    localparam int DIV = 2;
    localparam int LT = H_ACT * BPP + H_BLK;
    localparam int NL = V_BLK + V_ACT;
    localparam int FR = LT * NL;
`ifdef CAM_STIM_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_px = 16'h0000;
    logic        frame_done;
    logic [15:0] frame_cnt;

    cam_stim_gen_if cam_if ();

    cam_stim_gen #(
        .H_ACTIVE     (H_ACT),
        .V_ACTIVE     (V_ACT),
        .BYTES_PER_PX (BPP),
        .H_BLANK      (H_BLK),
        .V_BLANK      (V_BLK),
        .VSYNC_LINES  (VS_LINES),
        .PCLK_DIV     (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .solid_px   (solid_px),
        .cam        (cam_if),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_n = 0;

    always @(negedge clk) if (frame_done) done_n <= done_n + 1;

    logic [9:0] exp_s [FR];
    logic [7:0] cap_d [FR];

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] solid;
        int          line;
        logic [63:0] bytes;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [9:0] outs();
        return {cam_if.CAM_vsync, cam_if.CAM_href, cam_if.CAM_px_data};
    endfunction

    // Reference LFSR: taps listed as polynomial exponents, register shifts towards the MSB.
    function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
        int   taps [4] = '{16, 15, 13, 4};
        logic fb = 1'b0;
        foreach (taps[k]) fb = fb ^ s[taps[k] - 1];
        return {s[14:0], fb};
    endfunction

    function automatic logic [15:0] pixel(input logic [1:0] m, input logic [15:0] s,
                                          input int x, input int y, input logic [15:0] r);
        case (m)
            2'd1:    return 16'(x);
            2'd2:    return {8'(y), 8'(x)};
            2'd3:    return LFSR_ON ? r : s;
            default: return s;
        endcase
    endfunction

    // Expected {vsync, href, data} for every pclk of one frame.
    task automatic build_frame(input logic [1:0] m, input logic [15:0] s);
        logic [15:0] r;
        logic [15:0] px;
        logic        hr;
        logic        vs;
        r = 16'hACE1;
        for (int l = 0; l < NL; l++) begin
            for (int b = 0; b < LT; b++) begin
                vs = (l < VS_LINES);
                hr = (l >= V_BLK) && (b < H_ACT * BPP);
                px = pixel(m, s, b / BPP, l - V_BLK, r);
                exp_s[l * LT + b] = {vs, hr, hr ? ((BPP == 2 && b % 2 == 0) ? px[15:8] : px[7:0])
                                               : 8'h00};
                if (hr && (b % BPP == BPP - 1)) r = lfsr_ref(r);
            end
        end
    endtask

    task automatic sample();
        @(posedge cam_if.CAM_pclk);
        #1;
    endtask

    task automatic reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        @(negedge cam_if.CAM_pclk);
        repeat (2) @(negedge clk);
    endtask

    // Leaves the bench on the sample of line 0, byte 0.
    task automatic wait_sync();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 2 * FR; k++) begin
            sample();
            if (cam_if.CAM_vsync) begin
                ok = 1'b1;
                break;
            end
        end
        check("sync", 64'(ok), 64'd1);
    endtask

    // act: 1 = load next mode/solid at act_idx, 2 = drop en at act_idx.
    task automatic run_frame(input string name, input bit fresh, input int act_idx,
                             input int act, input logic [1:0] nm, input logic [15:0] ns);
        for (int i = 0; i < FR; i++) begin
            if (i > 0 || !fresh) sample();
            cap_d[i] = cam_if.CAM_px_data;
            check($sformatf("%s[%0d]", name, i), 64'(outs()), 64'(exp_s[i]));
            if (i == act_idx) begin
                if (act == 1) begin
                    mode = nm;
                    solid_px = ns;
                end else if (act == 2) begin
                    en = 1'b0;
                end
            end
        end
    endtask

    // Back-to-back frames; the config for frame f+1 is applied mid-way through frame f.
    task automatic stream(input string name, input int n, input logic [1:0] m0,
                          input logic [15:0] s0, input logic [1:0] m1, input logic [15:0] s1);
        logic [1:0]  cm, nm;
        logic [15:0] cs, ns;
        int          d0;
        reset();
        mode = m0;
        solid_px = s0;
        en = 1'b1;
        d0 = done_n;
        cm = m0; cs = s0; nm = m1; ns = s1;
        wait_sync();
        for (int f = 0; f < n; f++) begin
            build_frame(cm, cs);
            run_frame($sformatf("%s_f%0d", name, f), f == 0, FR / 2, 1, nm, ns);
            cm = nm;
            cs = ns;
            nm = 2'($urandom_range(0, 3));
            ns = 16'($urandom);
        end
        settle();
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(n));
        check({name, "_done_pulses"}, 64'(done_n - d0), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        logic [9:0]  acc;
        int          d0;
        int          k;
        longint      t0;

        vecs[0] = '{mode: 2'd0, solid: 16'hF00F, line: 4, bytes: 64'hF00F_F00F_F00F_F00F};
        vecs[1] = '{mode: 2'd1, solid: 16'h1234, line: 5, bytes: 64'h0000_0001_0002_0003};
        vecs[2] = '{mode: 2'd2, solid: 16'h0000, line: 5, bytes: 64'h0100_0101_0102_0103};
        vecs[3] = '{mode: 2'd2, solid: 16'hFFFF, line: 6, bytes: 64'h0200_0201_0202_0203};
`ifdef CAM_STIM_LFSR_EN
        vecs[4] = '{mode: 2'd3, solid: 16'h5AA5, line: 4, bytes: 64'hACE1_59C3_B386_670C};
`else
        vecs[4] = '{mode: 2'd3, solid: 16'h5AA5, line: 4, bytes: 64'h5AA5_5AA5_5AA5_5AA5};
`endif
        vecs[5] = '{mode: 2'd0, solid: 16'h00FF, line: 6, bytes: 64'h00FF_00FF_00FF_00FF};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_state", {cam_if.CAM_pclk, outs(), frame_done, frame_cnt}, 64'd0);
        rst = 1'b0;

        // Table: one frame per vector, chosen line compared against fixed bytes.
        for (int v = 0; v < 6; v++) begin
            reset();
            mode = vecs[v].mode;
            solid_px = vecs[v].solid;
            en = 1'b1;
            d0 = done_n;
            wait_sync();
            build_frame(vecs[v].mode, vecs[v].solid);
            run_frame($sformatf("vec%0d", v), 1'b1, -1, 0, 2'd0, 16'h0);
            got = '0;
            for (int b = 0; b < 8; b++) got = {got[55:0], cap_d[vecs[v].line * LT + b]};
            check($sformatf("vec%0d_line", v), got, vecs[v].bytes);
            settle();
            check($sformatf("vec%0d_frame_cnt", v), 64'(frame_cnt), 64'd1);
            check($sformatf("vec%0d_done", v), 64'(done_n - d0), 64'd1);
        end

        // Mode change mid-frame only affects the following frame.
        stream("modechg", 2, 2'd0, 16'hF00F, 2'd1, 16'h1234);
        // Randomized back-to-back frames.
        stream("rand", 6, 2'($urandom_range(0, 3)), 16'($urandom),
               2'($urandom_range(0, 3)), 16'($urandom));

        // en dropped on line 5: frame completes, then idle.
        reset();
        mode = 2'd0;
        solid_px = 16'h1234;
        en = 1'b1;
        d0 = done_n;
        wait_sync();
        build_frame(2'd0, 16'h1234);
        run_frame("endrop", 1'b1, 5 * LT, 2, 2'd0, 16'h0);
        settle();
        check("endrop_frame_cnt", 64'(frame_cnt), 64'd1);
        check("endrop_done", 64'(done_n - d0), 64'd1);
        acc = '0;
        for (int i = 0; i < 2 * LT; i++) begin
            sample();
            acc = acc | outs();
        end
        check("idle_outputs", 64'(acc), 64'd0);
        sample();
        t0 = $time;
        sample();
        check("idle_pclk_period", 64'($time - t0), 64'(2 * DIV * 10));

        // Reset mid-frame, then restart latency.
        reset();
        mode = 2'd0;
        solid_px = 16'hF00F;
        en = 1'b1;
        d0 = done_n;
        wait_sync();
        for (int i = 1; i <= 5 * LT + 2; i++) sample();
        check("pre_rst_href", 64'(cam_if.CAM_href), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", {cam_if.CAM_pclk, outs(), frame_done}, 64'd0);
        repeat (2) @(negedge clk);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_no_done", 64'(done_n - d0), 64'd0);
        rst = 1'b0;
        k = -1;
        for (int c = 1; c <= 4 * DIV + 2; c++) begin
            @(posedge clk);
            #1;
            if (cam_if.CAM_vsync) begin
                k = c;
                break;
            end
        end
        check("restart_latency", 64'(k), 64'(2 * DIV));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
